// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush sequencer for a five-stage MIPS pipeline. Resolves
//               load-use hazards, taken branches, jumps and multi-cycle data
//               memory accesses, and keeps saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_WriteRegister,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PC_enable,
  output logic        IFID_enable,
  output logic        IDEX_enable,
  output logic        EXMEM_enable,
  output logic        MEMWB_enable,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        MEMWB_flush,
  output logic        mem_error,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [7:0]  C_TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  w_wait_inc;
  logic        mem_error_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        w_lu;
  logic        w_ms;
  logic        w_run_rules;

  // Load-use: a load in EX writes a non-zero register read by the ID instruction.
  assign w_lu = IDEX_MemRead && (IDEX_WriteRegister != 5'd0) &&
                ((IDEX_WriteRegister == IFID_Rs) || (IDEX_WriteRegister == IFID_Rt));
  assign w_ms = mem_req && !mem_ready;
  assign w_wait_inc = wait_cnt_q + 8'd1;

  // Next-state and combinational pipeline controls; reset forces all bubbles.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    w_run_rules  = 1'b0;
    PC_enable    = 1'b1;
    IFID_enable  = 1'b1;
    IDEX_enable  = 1'b1;
    EXMEM_enable = 1'b1;
    MEMWB_enable = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    MEMWB_flush  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (w_ms) begin
          PC_enable    = 1'b0;
          IFID_enable  = 1'b0;
          IDEX_enable  = 1'b0;
          EXMEM_enable = 1'b0;
          MEMWB_flush  = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = 8'd1;
        end else begin
          w_run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          PC_enable    = 1'b0;
          IFID_enable  = 1'b0;
          IDEX_enable  = 1'b0;
          EXMEM_enable = 1'b0;
          MEMWB_flush  = 1'b1;
          wait_cnt_d   = w_wait_inc;
          // This cycle is waiting cycle number w_wait_inc.
          if (w_wait_inc == C_TIMEOUT) begin
            state_d = ST_MEM_ERR;
          end
        end else begin
          // Access completes: release in the same cycle, no extra bubble.
          w_run_rules = 1'b1;
          state_d     = ST_RUN;
          wait_cnt_d  = 8'd0;
        end
      end
      default: begin
        // Memory error (and any illegal encoding): freeze everything.
        PC_enable    = 1'b0;
        IFID_enable  = 1'b0;
        IDEX_enable  = 1'b0;
        EXMEM_enable = 1'b0;
        MEMWB_enable = 1'b0;
        MEMWB_flush  = 1'b1;
        state_d      = ST_MEM_ERR;
      end
    endcase

    // Normal hazard priority: branch, then load-use, then jump.
    if (w_run_rules) begin
      if (branch_taken) begin
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if (w_lu) begin
        PC_enable   = 1'b0;
        IFID_enable = 1'b0;
        IDEX_flush  = 1'b1;
      end else if (jump) begin
        IFID_flush = 1'b1;
      end
    end

    if (!reset) begin
      PC_enable    = 1'b0;
      IFID_enable  = 1'b0;
      IDEX_enable  = 1'b0;
      EXMEM_enable = 1'b0;
      MEMWB_enable = 1'b0;
      IFID_flush   = 1'b1;
      IDEX_flush   = 1'b1;
      MEMWB_flush  = 1'b1;
      state_d      = ST_RUN;
      wait_cnt_d   = 8'd0;
    end
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_q || (state_d == ST_MEM_ERR);
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!PC_enable && (stall_cnt_q != C_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (IFID_flush && (flush_cnt_q != C_CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign mem_error   = mem_error_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Self-checking bench for pipeline_hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  // Control word order: {PC,IFID,IDEX,EXMEM,MEMWB enables, IFID,IDEX,MEMWB flush}
  localparam logic [7:0] C_IDLE   = 8'b11111_000;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_BR     = 8'b11111_110;
  localparam logic [7:0] C_JMP    = 8'b11111_100;
  localparam logic [7:0] C_MSTALL = 8'b00001_001;
  localparam logic [7:0] C_ERR    = 8'b00000_001;
  localparam logic [7:0] C_RST    = 8'b00000_111;

  typedef struct packed {
    logic       memread;
    logic [4:0] wr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       jmp;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_WriteRegister;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        jump;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        PC_enable, IFID_enable, IDEX_enable, EXMEM_enable, MEMWB_enable;
  logic        IFID_flush, IDEX_flush, MEMWB_flush;
  logic        mem_error;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [7:0]  ctrl;

  int          n_tests;
  int          n_fail;
  logic [7:0]  exp_q[$];

  pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .IDEX_MemRead       (IDEX_MemRead),
    .IDEX_WriteRegister (IDEX_WriteRegister),
    .IFID_Rs            (IFID_Rs),
    .IFID_Rt            (IFID_Rt),
    .jump               (jump),
    .branch_taken       (branch_taken),
    .mem_req            (mem_req),
    .mem_ready          (mem_ready),
    .PC_enable          (PC_enable),
    .IFID_enable        (IFID_enable),
    .IDEX_enable        (IDEX_enable),
    .EXMEM_enable       (EXMEM_enable),
    .MEMWB_enable       (MEMWB_enable),
    .IFID_flush         (IFID_flush),
    .IDEX_flush         (IDEX_flush),
    .MEMWB_flush        (MEMWB_flush),
    .mem_error          (mem_error),
    .stall_count        (stall_count),
    .flush_count        (flush_count)
  );

  assign ctrl = {PC_enable, IFID_enable, IDEX_enable, EXMEM_enable, MEMWB_enable,
                 IFID_flush, IDEX_flush, MEMWB_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(input logic memread, input logic [4:0] wr, input logic [4:0] rs,
                             input logic [4:0] rt, input logic jmp, input logic br,
                             input logic req, input logic rdy);
    in_t v;
    v.memread = memread; v.wr = wr; v.rs = rs; v.rt = rt;
    v.jmp = jmp; v.br = br; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  task automatic set_in(input in_t v);
    IDEX_MemRead       = v.memread;
    IDEX_WriteRegister = v.wr;
    IFID_Rs            = v.rs;
    IFID_Rt            = v.rt;
    jump               = v.jmp;
    branch_taken       = v.br;
    mem_req            = v.req;
    mem_ready          = v.rdy;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected controls, compare mid-cycle.
  task automatic step(input string name, input in_t v, input logic [7:0] exp);
    logic [7:0] e;
    set_in(v);
    exp_q.push_back(exp);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b expected entry", name, ctrl);
    end else begin
      e = exp_q.pop_front();
      n_tests--;
      chk8(name, ctrl, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; outputs must take reset values with no clock edge.
  task automatic reset_pulse(input string name);
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    chk8({name, "_rst_ctrl"}, ctrl, C_RST);
    chk16({name, "_rst_stall"}, stall_count, 16'd0);
    chk16({name, "_rst_flush"}, flush_count, 16'd0);
    chk8({name, "_rst_err"}, {7'd0, mem_error}, 8'd0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[10];
  int          exp_stalls;
  int          exp_flushes;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state, then RUN behaviour in the same cycle as release.
    #1;
    chk8("reset_ctrl", ctrl, C_RST);
    chk16("reset_stall", stall_count, 16'd0);
    chk16("reset_flush", flush_count, 16'd0);
    chk8("reset_err", {7'd0, mem_error}, 8'd0);
    #1;
    reset = 1'b1;
    #1;
    chk8("release_run", ctrl, C_IDLE);
    @(posedge clk);
    #1;

    // Single-cycle RUN vectors.
    tbl[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), C_IDLE};
    tbl[1] = '{mk(1, 8, 8, 3, 0, 0, 0, 0), C_LU};
    tbl[2] = '{mk(1, 0, 0, 0, 0, 0, 0, 0), C_IDLE};
    tbl[3] = '{mk(1, 8, 2, 8, 0, 0, 0, 0), C_LU};
    tbl[4] = '{mk(0, 8, 8, 8, 0, 0, 0, 0), C_IDLE};
    tbl[5] = '{mk(1, 8, 8, 3, 0, 1, 0, 0), C_BR};
    tbl[6] = '{mk(1, 8, 8, 3, 1, 0, 0, 0), C_LU};
    tbl[7] = '{mk(0, 0, 0, 0, 1, 0, 0, 0), C_JMP};
    tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), C_IDLE};
    tbl[9] = '{mk(0, 0, 0, 0, 1, 1, 0, 0), C_BR};
    exp_stalls  = 0;
    exp_flushes = 0;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
      if (!tbl[i].exp[7]) exp_stalls++;
      if (tbl[i].exp[2]) exp_flushes++;
    end
    chk16("vec_stall_count", stall_count, 16'(exp_stalls));
    chk16("vec_flush_count", flush_count, 16'(exp_flushes));

    // Load-use costs exactly one bubble.
    reset_pulse("lu");
    step("lu_bubble", mk(1, 8, 8, 0, 0, 0, 0, 0), C_LU);
    step("lu_after", mk(0, 0, 0, 0, 0, 0, 0, 0), C_IDLE);
    chk16("lu_stall_count", stall_count, 16'd1);

    // Memory wait of three cycles, branch ignored while stalled.
    reset_pulse("mw");
    step("mw_c1", mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
    step("mw_c2_br", mk(0, 0, 0, 0, 0, 1, 1, 0), C_MSTALL);
    step("mw_c3", mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
    step("mw_release", mk(0, 0, 0, 0, 0, 0, 1, 1), C_IDLE);
    step("mw_run", mk(0, 0, 0, 0, 0, 0, 0, 0), C_IDLE);
    chk16("mw_stall_count", stall_count, 16'd3);
    chk16("mw_flush_count", flush_count, 16'd0);

    // Release cycle applies RUN rules (load-use seen immediately).
    reset_pulse("mwlu");
    step("mwlu_c1", mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
    step("mwlu_c2", mk(1, 8, 8, 0, 0, 0, 1, 0), C_MSTALL);
    step("mwlu_rel", mk(1, 8, 8, 0, 0, 0, 1, 1), C_LU);
    step("mwlu_run", mk(0, 0, 0, 0, 0, 0, 0, 0), C_IDLE);
    chk16("mwlu_stall_count", stall_count, 16'd3);

    // Timeout after four waiting cycles.
    reset_pulse("to");
    for (int i = 0; i < 4; i++) begin
      step($sformatf("to_wait%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
      if (i == 2) chk8("to_err_early", {7'd0, mem_error}, 8'd0);
    end
    chk8("to_err_set", {7'd0, mem_error}, 8'd1);
    step("to_err_ctrl", mk(0, 0, 0, 0, 1, 1, 1, 1), C_ERR);
    chk8("to_err_sticky", {7'd0, mem_error}, 8'd1);
    chk16("to_stall_count", stall_count, 16'd5);
    reset_pulse("to_clear");
    step("to_run", mk(0, 0, 0, 0, 0, 0, 0, 0), C_IDLE);
    chk8("to_err_clear", {7'd0, mem_error}, 8'd0);

    // Saturation of the stall counter inside the error state.
    reset_pulse("sat");
    for (int i = 0; i < 4; i++) begin
      step($sformatf("sat_wait%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
    end
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    chk16("sat_stall_max", stall_count, 16'hFFFF);
    step("sat_err_ctrl", mk(0, 0, 0, 0, 0, 0, 0, 0), C_ERR);
    chk16("sat_stall_hold", stall_count, 16'hFFFF);
    chk16("sat_flush", flush_count, 16'd0);

    // Asynchronous reset in the middle of a memory stall.
    reset_pulse("mid");
    step("mid_c1", mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
    step("mid_c2", mk(0, 0, 0, 0, 0, 0, 1, 0), C_MSTALL);
    chk16("mid_stall_pre", stall_count, 16'd2);
    reset = 1'b0;
    #1;
    chk8("mid_rst_ctrl", ctrl, C_RST);
    chk16("mid_rst_stall", stall_count, 16'd0);
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #1;
    chk8("mid_run_ctrl", ctrl, C_IDLE);
    @(posedge clk);
    #1;
    step("mid_run_step", mk(0, 0, 0, 0, 0, 0, 0, 0), C_IDLE);
    chk16("mid_stall_post", stall_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall and flush sequencer for the five-stage MIPS pipeline. It drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles four cases: load-use hazards, taken branches, jumps, and multi-cycle data-memory accesses. It also keeps saturating performance counters for stall and flush events.

## Interface
- MEM_TIMEOUT, 15: maximum number of consecutive MEM_WAIT cycles before the error state; legal range 2..255.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- IDEX_MemRead  input  1  the instruction in EX is a load.
- IDEX_WriteRegister  input  5  destination register of the instruction in EX.
- IFID_Rs, IFID_Rt  input  5 each  source registers of the instruction in ID.
- jump  input  1  a jump has been decoded in ID.
- branch_taken  input  1  a branch resolved as taken in EX.
- mem_req  input  1  the EX/MEM instruction accesses data memory this cycle.
- mem_ready  input  1  data memory completes the access this cycle.
- PC_enable, IFID_enable, IDEX_enable, EXMEM_enable, MEMWB_enable  output  1 each  register load enables.
- IFID_flush, IDEX_flush, MEMWB_flush  output  1 each  the register loads a bubble (all control zero) when enabled.
- mem_error  output  1  sticky memory-timeout flag.
- stall_count  output  16  cycles with PC_enable=0, saturating at 0xFFFF.
- flush_count  output  16  cycles with IFID_flush=1, saturating at 0xFFFF.

## Operation
- The FSM has three states: RUN, MEM_WAIT and MEM_ERR. The reset state is RUN.
- Control outputs are combinational functions of the state and the inputs. Counters, wait count and mem_error are registered.
- A load-use hazard (LU) is defined as: IDEX_MemRead=1, IDEX_WriteRegister≠0, and IDEX_WriteRegister equals IFID_Rs or IFID_Rt.
- A memory stall (MS) is defined as: mem_req=1 and mem_ready=0.
- In RUN, the first matching rule applies:
  - MS: PC, IFID, IDEX and EXMEM enables are 0. MEMWB_enable=1 and MEMWB_flush=1. Next state is MEM_WAIT with wait count 1.
  - branch_taken: all enables are 1. IFID_flush=1 and IDEX_flush=1. LU and jump are ignored.
  - LU: PC_enable=0, IFID_enable=0, IDEX_enable=1, IDEX_flush=1. A simultaneous jump is ignored and re-evaluated next cycle.
  - jump: all enables are 1 and IFID_flush=1.
  - Otherwise: all enables are 1 and all flushes are 0.
- In MEM_WAIT:
  - mem_ready=0: hold the same outputs as MS and increment the wait count. If the wait count equals MEM_TIMEOUT, go to MEM_ERR.
  - mem_ready=1: apply the RUN rules, with MS false, in the same cycle, then return to RUN.
  - branch_taken, jump and LU are ignored while stalled. ID/EX is frozen, so they re-present after release.
- In MEM_ERR: all enables are 0, MEMWB_flush=1, and mem_error=1. The block leaves this state only on reset.
- stall_count increments on every cycle with PC_enable=0, including MEM_ERR. It saturates and does not wrap.
- flush_count increments on every cycle with IFID_flush=1. It saturates.

## Timing
- While reset=0:
  - All enables are 0.
  - IFID_flush, IDEX_flush and MEMWB_flush are 1.
  - mem_error=0, stall_count=0, flush_count=0.
  - State is RUN and wait count is 0.
- After reset is released, outputs follow the RUN rules in the same cycle.
- Hazard response has zero-cycle latency, combinational from the inputs.
- A load-use hazard costs exactly one bubble cycle: the next cycle, the load sits in MEM and LU is false.
- A memory access that completes after k cycles of mem_ready=0 costs k stall cycles. There is no extra release cycle.
- Timeout: the cycle after the MEM_TIMEOUT-th consecutive waiting cycle is in MEM_ERR, and mem_error rises on that edge.
- Asserting reset mid-stall or in MEM_ERR returns the block to RUN immediately and asynchronously.
- Counter outputs update one cycle after the event they count.

## Test plan
- LU: IDEX_MemRead=1, IDEX_WriteRegister=8, IFID_Rs=8 for one cycle, then idle.
  - Expect PC_enable=0, IFID_enable=0, IDEX_flush=1 for exactly one cycle, then stall_count=1.
  - Repeat with IDEX_WriteRegister=0: expect no stall.
- Branch vs LU:
  - branch_taken=1 together with the LU condition above: expect all enables 1, IFID_flush=1 and IDEX_flush=1.
  - jump=1 together with LU: expect the LU stall and no IFID_flush.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1.
  - Expect 3 frozen cycles with MEMWB_flush=1 and release in the 4th cycle.
  - Then stall_count=3.
  - branch_taken=1 during the wait produces no flush.
- Timeout: MEM_TIMEOUT=4 with mem_ready held at 0.
  - Expect MEM_ERR and mem_error=1 after 4 wait cycles, with all enables staying 0.
  - Pulse reset low: expect RUN, mem_error=0 and counters at 0.
- Saturation: force 70000 stall cycles in MEM_ERR.
  - Expect stall_count=0xFFFF with no wrap.
- Reset mid-stall: assert reset in cycle 2 of MEM_WAIT.
  - Expect all reset values immediately, without waiting for a clock edge.
